// File: rtl/ribbon_accumulator_pkg.sv
// Shared definitions for the day-2 part-2 ribbon accumulator.
//   state_e    : top-level control states
//   PIPE_DEPTH : number of pipeline stages carrying a valid bit
package ribbon_accumulator_pkg;

  typedef enum logic [1:0] {
    StAccumulate,
    StDrain,
    StDone
  } state_e;

  localparam int unsigned PIPE_DEPTH = 3;

endpackage

// File: rtl/box_ribbon_pipe.sv
// Two-stage per-box ribbon calculator.
//   S1 registers the smallest-perimeter term 2*(a+b), the partial product l*w and h.
//   S2 registers box = l*w*h + 2*(a+b).
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   valid                 : box dimensions valid this cycle
//   length/width/height   : box dimensions, unsigned
//   s1_valid              : S1 holds a box
//   box_valid, box        : S2 result and its valid bit
module box_ribbon_pipe #(
  parameter int unsigned SIZE_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    valid,
  input  logic [SIZE_WIDTH-1:0]   length,
  input  logic [SIZE_WIDTH-1:0]   width,
  input  logic [SIZE_WIDTH-1:0]   height,
  output logic                    s1_valid,
  output logic                    box_valid,
  output logic [3*SIZE_WIDTH:0]   box
);

  localparam int unsigned PairWidth  = SIZE_WIDTH + 1;
  localparam int unsigned PerimWidth = SIZE_WIDTH + 2;
  localparam int unsigned LwWidth    = 2 * SIZE_WIDTH;
  localparam int unsigned VolWidth   = 3 * SIZE_WIDTH;
  localparam int unsigned BoxWidth   = 3 * SIZE_WIDTH + 1;

  logic [PairWidth-1:0]  pair_sum;
  logic [LwWidth-1:0]    lw_d, lw_q;
  logic [PerimWidth-1:0] perim_q;
  logic [SIZE_WIDTH-1:0] h_q;
  logic                  s1_valid_q, s2_valid_q;
  logic [VolWidth-1:0]   vol;
  logic [BoxWidth-1:0]   box_d, box_q;

  // Drop the first maximum in l,w,h order; ties give the same sum either way.
  always_comb begin
    if (length >= width && length >= height) begin
      pair_sum = PairWidth'(width) + PairWidth'(height);
    end else if (width >= height) begin
      pair_sum = PairWidth'(length) + PairWidth'(height);
    end else begin
      pair_sum = PairWidth'(length) + PairWidth'(width);
    end
    lw_d  = LwWidth'(length) * LwWidth'(width);
    vol   = VolWidth'(lw_q) * VolWidth'(h_q);
    box_d = BoxWidth'(vol) + BoxWidth'(perim_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= valid;
      s2_valid_q <= s1_valid_q;
    end
  end

  // Data registers need no reset; the valid bits qualify them.
  always_ff @(posedge clk) begin
    perim_q <= {pair_sum, 1'b0};
    lw_q    <= lw_d;
    h_q     <= height;
    box_q   <= box_d;
  end

  assign s1_valid  = s1_valid_q;
  assign box_valid = s2_valid_q;
  assign box       = box_q;

endmodule

// File: rtl/ribbon_accumulator.sv
// Accumulates the ribbon length of every decoded box and presents the final total
// once end_of_file has been seen and the pipeline has drained.
// Ports:
//   clk, reset                : clock, synchronous active-high reset
//   end_of_file               : input stream finished (held high once set)
//   size_valid                : one-cycle pulse, length/width/height valid
//   length/width/height       : box dimensions, unsigned
//   result_valid              : final total valid, held until reset
//   result                    : running / final total, modulo 2**RESULT_WIDTH
//   overflow                  : sticky, accumulator wrapped at least once
module ribbon_accumulator
  import ribbon_accumulator_pkg::*;
#(
  parameter int unsigned SIZE_WIDTH   = 8,
  parameter int unsigned RESULT_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    end_of_file,
  input  logic                    size_valid,
  input  logic [SIZE_WIDTH-1:0]   length,
  input  logic [SIZE_WIDTH-1:0]   width,
  input  logic [SIZE_WIDTH-1:0]   height,
  output logic                    result_valid,
  output logic [RESULT_WIDTH-1:0] result,
  output logic                    overflow
);

  localparam int unsigned BoxWidth = 3 * SIZE_WIDTH + 1;
  // One bit wider than the wider operand so any wrap shows up above RESULT_WIDTH.
  localparam int unsigned SumWidth =
      ((RESULT_WIDTH > BoxWidth) ? RESULT_WIDTH : BoxWidth) + 1;

  state_e                  state_q, state_d;
  logic                    accept;
  logic                    s1_valid, box_valid, s3_valid_q;
  logic [BoxWidth-1:0]     box;
  logic [PIPE_DEPTH-1:0]   stage_valid;
  logic [SumWidth-1:0]     sum;
  logic [RESULT_WIDTH-1:0] acc_q, acc_d;
  logic                    ovf_q, ovf_d;

  box_ribbon_pipe #(
    .SIZE_WIDTH (SIZE_WIDTH)
  ) u_pipe (
    .clk       (clk),
    .reset     (reset),
    .valid     (accept),
    .length    (length),
    .width     (width),
    .height    (height),
    .s1_valid  (s1_valid),
    .box_valid (box_valid),
    .box       (box)
  );

  assign stage_valid = {s3_valid_q, box_valid, s1_valid};

  // S3: accumulate with wrap; any bit at or above RESULT_WIDTH marks a wrap.
  always_comb begin
    sum   = SumWidth'(acc_q) + SumWidth'(box);
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (box_valid && state_q != StDone) begin
      acc_d = sum[RESULT_WIDTH-1:0];
      if (sum[SumWidth-1:RESULT_WIDTH] != '0) begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q      <= '0;
      ovf_q      <= 1'b0;
      s3_valid_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      ovf_q      <= ovf_d;
      s3_valid_q <= box_valid;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StAccumulate;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StAccumulate: if (end_of_file) state_d = StDrain;
      StDrain:      if (stage_valid == '0) state_d = StDone;
      StDone:       state_d = StDone;
      default:      state_d = StAccumulate;
    endcase
  end

  // FSM outputs; result_valid rises together with the entry into StDone.
  always_comb begin
    accept       = (state_q == StAccumulate) && size_valid && !end_of_file;
    result_valid = (state_q == StDone);
  end

  assign result   = acc_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_ribbon_accumulator.sv
module tb_ribbon_accumulator;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        end_of_file = 1'b0;
  logic        size_valid = 1'b0;
  logic [7:0]  length = '0, width = '0, height = '0;
  logic        rv32, rv24, ov32, ov24;
  logic [31:0] res32;
  logic [23:0] res24;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ribbon_accumulator #(.SIZE_WIDTH(8), .RESULT_WIDTH(32)) dut32 (
    .clk (clk), .reset (reset), .end_of_file (end_of_file), .size_valid (size_valid),
    .length (length), .width (width), .height (height),
    .result_valid (rv32), .result (res32), .overflow (ov32)
  );

  ribbon_accumulator #(.SIZE_WIDTH(8), .RESULT_WIDTH(24)) dut24 (
    .clk (clk), .reset (reset), .end_of_file (end_of_file), .size_valid (size_valid),
    .length (length), .width (width), .height (height),
    .result_valid (rv24), .result (res24), .overflow (ov24)
  );

  typedef struct {
    logic [7:0]  l;
    logic [7:0]  w;
    logic [7:0]  h;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference: sort the three sides, keep the two smallest.
  function automatic logic [63:0] ribbon(input int l, input int w, input int h);
    int s[3];
    int t;
    s[0] = l; s[1] = w; s[2] = h;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2 - i; j++)
        if (s[j] > s[j+1]) begin t = s[j]; s[j] = s[j+1]; s[j+1] = t; end
    return 64'(2 * (s[0] + s[1])) + 64'(l) * 64'(w) * 64'(h);
  endfunction

  task automatic put(input int l, input int w, input int h, input bit v = 1'b1);
    length = 8'(l); width = 8'(w); height = 8'(h); size_valid = v;
    @(negedge clk);
  endtask

  task automatic do_reset(input string name);
    reset = 1'b1; end_of_file = 1'b0; size_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    check({name, "_rst_result"}, {32'd0, res32}, 64'd0);
    check({name, "_rst_valid"}, {63'd0, rv32}, 64'd0);
    check({name, "_rst_ovf"}, {63'd0, ov24}, 64'd0);
  endtask

  task automatic finish_run(input string name, input logic [63:0] total);
    bit got = 1'b0;
    size_valid = 1'b0;
    end_of_file = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rv32 && rv24) begin got = 1'b1; break; end
    end
    check({name, "_valid"}, {63'd0, got}, 64'd1);
    check({name, "_result32"}, {32'd0, res32}, {32'd0, total[31:0]});
    check({name, "_result24"}, {40'd0, res24}, {40'd0, total[23:0]});
    check({name, "_ovf32"}, {63'd0, ov32}, {63'd0, total >= 64'h1_0000_0000});
    check({name, "_ovf24"}, {63'd0, ov24}, {63'd0, total >= 64'h100_0000});
    // Boxes offered after completion must not disturb the frozen total.
    put(200, 100, 50);
    put(7, 8, 9);
    size_valid = 1'b0;
    repeat (4) @(negedge clk);
    check({name, "_frozen_result"}, {32'd0, res32}, {32'd0, total[31:0]});
    check({name, "_frozen_valid"}, {63'd0, rv32}, 64'd1);
  endtask

  initial begin
    logic [63:0] total;
    vecs[0] = '{l: 8'd2,   w: 8'd3,   h: 8'd4,   exp: 64'd34};
    vecs[1] = '{l: 8'd1,   w: 8'd1,   h: 8'd10,  exp: 64'd14};
    vecs[2] = '{l: 8'd5,   w: 8'd5,   h: 8'd5,   exp: 64'd145};
    vecs[3] = '{l: 8'd3,   w: 8'd3,   h: 8'd1,   exp: 64'd17};
    vecs[4] = '{l: 8'd255, w: 8'd255, h: 8'd255, exp: 64'd16582395};
    vecs[5] = '{l: 8'd1,   w: 8'd1,   h: 8'd1,   exp: 64'd5};
    vecs[6] = '{l: 8'd0,   w: 8'd7,   h: 8'd9,   exp: 64'd14};

    @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      do_reset($sformatf("vec%0d", i));
      put(vecs[i].l, vecs[i].w, vecs[i].h);
      finish_run($sformatf("vec%0d", i), vecs[i].exp);
    end

    // End of file with no boxes.
    do_reset("empty");
    finish_run("empty", 64'd0);

    // Back-to-back boxes, EOF right after; valid must wait for both to land.
    do_reset("b2b");
    put(2, 3, 4);
    put(1, 1, 10);
    size_valid = 1'b0; end_of_file = 1'b1;
    @(negedge clk);
    check("b2b_early_valid", {63'd0, rv32}, 64'd0);
    finish_run("b2b", 64'd48);

    do_reset("ties");
    put(5, 5, 5);
    put(3, 3, 1);
    finish_run("ties", 64'd162);

    // Wraps the 24-bit instance only.
    do_reset("wrap");
    put(255, 255, 255);
    put(255, 255, 255);
    finish_run("wrap", 64'd33164790);

    // Reset while draining with boxes in flight.
    do_reset("mid");
    put(2, 3, 4);
    put(5, 5, 5);
    size_valid = 1'b0; end_of_file = 1'b1;
    @(negedge clk);
    check("mid_drain_valid", {63'd0, rv32}, 64'd0);
    do_reset("mid2");
    put(1, 1, 1);
    finish_run("mid", 64'd5);

    // A box presented in the same cycle as end_of_file is ignored.
    do_reset("eofgate");
    put(2, 3, 4);
    end_of_file = 1'b1;
    put(9, 9, 9);
    finish_run("eofgate", 64'd34);

    // Random streams with gaps, invalid garbage and extreme sides.
    for (int r = 0; r < 4; r++) begin
      int n;
      do_reset($sformatf("rand%0d", r));
      total = '0;
      n = $urandom_range(60, 5);
      for (int k = 0; k < n; k++) begin
        int l, w, h;
        bit v;
        l = ($urandom_range(3, 0) == 0) ? 255 : $urandom_range(255, 0);
        w = ($urandom_range(3, 0) == 0) ? 255 : $urandom_range(255, 0);
        h = ($urandom_range(5, 0) == 0) ? 0 : $urandom_range(255, 0);
        v = ($urandom_range(3, 0) != 0);
        if (v) total += ribbon(l, w, h);
        put(l, w, h, v);
      end
      finish_run($sformatf("rand%0d", r), total);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
